// File: rtl/tuart_cmd_rx.sv
// tuart_cmd_rx
//   Tiny-UART command receiver. Synchronises and majority-samples a serial line,
//   checks stop (and optional parity) bits, and assembles SUMP-style commands:
//   an opcode with MSB 0 is a complete short command; an opcode with MSB 1
//   starts a long command of CMD_WIDTH_WORDS words. A partial long command is
//   dropped silently after TIMEOUT_BITS idle bit-times.
// Ports:
//   clk_i       single clock
//   rst_in      asynchronous active-low reset
//   rx_async_i  raw serial line, idle high
//   data_o      assembled command, opcode in the top DATA_BITS bits
//   rdy_o       one-cycle pulse, data_o valid
//   long_o      qualifies rdy_o: 1 = long command
//   err_o       one-cycle pulse, framing or parity error
module tuart_cmd_rx #(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned CMD_WIDTH_WORDS = 5,
  parameter int unsigned CLK_PER_SAMPLE  = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned TIMEOUT_BITS    = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_in,
  input  logic                                 rx_async_i,
  output logic [DATA_BITS*CMD_WIDTH_WORDS-1:0] data_o,
  output logic                                 rdy_o,
  output logic                                 long_o,
  output logic                                 err_o
);

  localparam int unsigned H    = CLK_PER_SAMPLE / 2;
  localparam int unsigned CW   = $clog2(CLK_PER_SAMPLE);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned WW   = $clog2(CMD_WIDTH_WORDS);
  localparam int unsigned TLIM = TIMEOUT_BITS * CLK_PER_SAMPLE;
  localparam int unsigned TW   = $clog2(TLIM + 1);
  localparam int unsigned CMDW = DATA_BITS * CMD_WIDTH_WORDS;

  localparam logic [CW-1:0] CNT_HM1   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_H     = CW'(H);
  localparam logic [CW-1:0] CNT_HP1   = CW'(H + 1);
  localparam logic [CW-1:0] CNT_END   = CW'(CLK_PER_SAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(CMD_WIDTH_WORDS - 1);
  localparam logic [TW-1:0] TLIM_M1   = TW'(TLIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_prev;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_ok;
  logic                   s0, s1, vote;
  logic                   at_hm1, at_h, at_hp1, at_end;
  logic                   start_edge, stop_hit, frame_ok, frame_err;
  logic [WW-1:0]          wcnt;
  logic [CMDW-1:0]        acc, acc_shift;
  logic [TW-1:0]          tcnt;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) sync <= '1;
    else         sync <= {sync[SYNC_STAGES-2:0], rx_async_i};
  end

  assign rx_s   = sync[SYNC_STAGES-1];
  assign at_hm1 = (cnt == CNT_HM1);
  assign at_h   = (cnt == CNT_H);
  assign at_hp1 = (cnt == CNT_HP1);
  assign at_end = (cnt == CNT_END);

  // s0/s1 hold the samples at H-1 and H; the third vote is the live line at H+1.
  assign vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign start_edge = (state == S_IDLE) && rx_prev && !rx_s;

  // Stop decision is combinational so the outputs register on the sample clock itself.
  assign stop_hit  = (state == S_STOP) && at_hp1;
  assign frame_ok  = stop_hit && vote && par_ok;
  assign frame_err = stop_hit && !(vote && par_ok);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state   <= S_IDLE;
      rx_prev <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_ok  <= 1'b1;
      s0      <= 1'b1;
      s1      <= 1'b1;
    end else begin
      rx_prev <= rx_s;
      if (at_hm1) s0 <= rx_s;
      if (at_h)   s1 <= rx_s;
      cnt <= at_end ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start_edge) begin
            state  <= S_START;
            par_ok <= 1'b1;
          end
        end
        S_START: begin
          if (at_hp1 && vote) state <= S_IDLE;
          else if (at_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (at_hp1) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_idx == LAST_BIT) state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        S_PARITY: begin
          if (at_hp1) par_ok <= (((^shreg) ^ vote) == (PARITY == 1));
          if (at_end) state <= S_STOP;
        end
        S_STOP: begin
          // Leave at the stop sample so a back-to-back start edge is not missed.
          if (at_hp1) state <= vote ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Words shift in from the LSB end, so after CMD_WIDTH_WORDS words the opcode sits on top.
  assign acc_shift = {acc[CMDW-DATA_BITS-1:0], shreg};

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wcnt   <= '0;
      acc    <= '0;
      tcnt   <= '0;
      data_o <= '0;
      rdy_o  <= 1'b0;
      long_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      rdy_o <= 1'b0;
      err_o <= 1'b0;
      if (frame_err) begin
        err_o <= 1'b1;
        wcnt  <= '0;
      end else if (frame_ok) begin
        acc <= acc_shift;
        if (wcnt == '0 && !shreg[DATA_BITS-1]) begin
          data_o <= {shreg, {(CMDW-DATA_BITS){1'b0}}};
          long_o <= 1'b0;
          rdy_o  <= 1'b1;
        end else if (wcnt == LAST_WORD) begin
          data_o <= acc_shift;
          long_o <= 1'b1;
          rdy_o  <= 1'b1;
          wcnt   <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      // A start edge outranks an expiring timeout, keeping the partial command.
      if (start_edge) begin
        tcnt <= '0;
      end else if (state == S_IDLE && wcnt != '0) begin
        if (tcnt == TLIM_M1) begin
          tcnt <= '0;
          wcnt <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tuart_cmd_rx.sv
// Testbench for tuart_cmd_rx: channel 0 uses default parameters, channel 1
// uses even parity. A word-level model predicts each pulse and the held output.
module tb_tuart_cmd_rx;

  localparam int CPS  = 10;
  localparam int H    = CPS / 2;
  localparam int SYNC = 2;
  localparam int NW   = 5;
  localparam int TOB  = 32;
  localparam int W    = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_a = 1'b1, rx_b = 1'b1;
  logic [W-1:0] data_a, data_b;
  logic         rdy_a, long_a, err_a, rdy_b, long_b, err_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit run_chk = 1'b0;

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    bit           lng;
    int           fall;
  } ev_t;

  ev_t          expq[2][$];
  logic [7:0]   part[2][$];
  logic [W-1:0] hold_d[2];
  bit           hold_l[2];
  int           last_lat[2];
  int           n_rdy[2];
  int           n_err[2];

  tuart_cmd_rx dut_a (
    .clk_i(clk), .rst_in(rst_n), .rx_async_i(rx_a),
    .data_o(data_a), .rdy_o(rdy_a), .long_o(long_a), .err_o(err_a)
  );

  tuart_cmd_rx #(.PARITY(2)) dut_b (
    .clk_i(clk), .rst_in(rst_n), .rx_async_i(rx_b),
    .data_o(data_b), .rdy_o(rdy_b), .long_o(long_b), .err_o(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      expq[c].delete();
      part[c].delete();
      hold_d[c] = '0;
      hold_l[c] = 1'b0;
    end
  endtask

  // Word-level command rules: bad word clears everything, idle gap of
  // TIMEOUT_BITS or more drops a partial command, MSB selects short/long.
  task automatic model_word(input int ch, input logic [7:0] w, input logic pbit,
                            input logic stop, input int gap, input int fall);
    ev_t e;
    logic [W-1:0] d;
    bit ok;
    ok = stop && (ch == 0 || ((^w) ^ pbit) == 1'b0);
    e.fall = fall;
    if (gap >= TOB) part[ch].delete();
    if (!ok) begin
      part[ch].delete();
      e.is_err = 1'b1; e.data = '0; e.lng = 1'b0;
      expq[ch].push_back(e);
    end else if (part[ch].size() == 0 && !w[7]) begin
      e.is_err = 1'b0; e.data = {w, 32'h0}; e.lng = 1'b0;
      expq[ch].push_back(e);
    end else begin
      part[ch].push_back(w);
      if (part[ch].size() == NW) begin
        d = '0;
        for (int i = 0; i < NW; i++) d = {d[W-9:0], part[ch][i]};
        e.is_err = 1'b0; e.data = d; e.lng = 1'b1;
        expq[ch].push_back(e);
        part[ch].delete();
      end
    end
  endtask

  task automatic drive(input int ch, input logic v);
    if (ch == 0) rx_a = v;
    else         rx_b = v;
  endtask

  task automatic send(input int ch, input logic [7:0] w, input logic pbit,
                      input logic stop, input int gap, input int glitch_bit);
    logic [10:0] bits;
    int n;
    repeat (gap * CPS) @(negedge clk);
    n = (ch == 0) ? 10 : 11;
    bits = '0;
    bits[8:1] = w;
    if (ch == 1) begin
      bits[9]  = pbit;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    model_word(ch, w, pbit, stop, gap, cyc);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < CPS; j++) begin
        drive(ch, (i == glitch_bit && j == H) ? ~bits[i] : bits[i]);
        @(negedge clk);
      end
  endtask

  task automatic chk(input int ch, input logic rdy, input logic err,
                     input logic [W-1:0] d, input logic lng);
    ev_t e;
    int exp_lat;
    cmp("rdy_err_exclusive", 64'(rdy & err), 64'(0));
    if (rdy === 1'b1 || err === 1'b1) begin
      if (rdy === 1'b1) n_rdy[ch]++;
      if (err === 1'b1) n_err[ch]++;
      if (expq[ch].size() == 0) begin
        cmp("unexpected_pulse", 64'({rdy, err}), 64'(0));
      end else begin
        e = expq[ch].pop_front();
        cmp("pulse_kind_err", 64'(err), 64'(e.is_err));
        if (!e.is_err) begin
          hold_d[ch] = e.data;
          hold_l[ch] = e.lng;
        end
        last_lat[ch] = cyc - e.fall;
        exp_lat = SYNC + (((ch == 0) ? 10 : 11) - 1) * CPS + H + 3;
        cmp("pulse_latency", 64'(last_lat[ch]), 64'(exp_lat));
      end
    end
    cmp("data_o_hold", 64'(d), 64'(hold_d[ch]));
    cmp("long_o_hold", 64'(lng), 64'(hold_l[ch]));
  endtask

  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      chk(0, rdy_a, err_a, data_a, long_a);
      chk(1, rdy_b, err_b, data_b, long_b);
    end
  end

  task automatic drain();
    repeat (3 * CPS) @(negedge clk);
    cmp("pending_ch0", 64'(expq[0].size()), 64'(0));
    cmp("pending_ch1", 64'(expq[1].size()), 64'(0));
  endtask

  initial begin
    int r0, e0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      n_rdy[c] = 0; n_err[c] = 0; last_lat[c] = 0;
    end
    repeat (3) @(negedge clk);
    cmp("reset_data", 64'(data_a), 64'(0));
    cmp("reset_rdy", 64'(rdy_a), 64'(0));
    cmp("reset_long", 64'(long_a), 64'(0));
    cmp("reset_err", 64'(err_a), 64'(0));
    rst_n = 1'b1;
    run_chk = 1'b1;
    repeat (5) @(negedge clk);

    // short command and end-to-end latency
    send(0, 8'h01, 1'b0, 1'b1, 0, -1);
    drain();
    cmp("short_data", 64'(data_a), 64'(40'h0100000000));
    cmp("short_long", 64'(long_a), 64'(0));
    cmp("short_latency", 64'(last_lat[0]), 64'(100));

    // long command, back-to-back, single pulse
    r0 = n_rdy[0];
    send(0, 8'h80, 1'b0, 1'b1, 0, -1);
    send(0, 8'h11, 1'b0, 1'b1, 0, -1);
    send(0, 8'h22, 1'b0, 1'b1, 0, -1);
    send(0, 8'h33, 1'b0, 1'b1, 0, -1);
    send(0, 8'h44, 1'b0, 1'b1, 0, -1);
    drain();
    cmp("long_data", 64'(data_a), 64'(40'h8011223344));
    cmp("long_long", 64'(long_a), 64'(1));
    cmp("long_rdy_count", 64'(n_rdy[0] - r0), 64'(1));

    // framing error, line held low, then a short command
    e0 = n_err[0];
    send(0, 8'h80, 1'b0, 1'b0, 0, -1);
    repeat (3 * CPS) @(negedge clk);
    drive(0, 1'b1);
    send(0, 8'h02, 1'b0, 1'b1, 1, -1);
    drain();
    cmp("frame_err_count", 64'(n_err[0] - e0), 64'(1));
    cmp("after_break_data", 64'(data_a), 64'(40'h0200000000));

    // even parity: correct bit accepted, wrong bit flagged
    send(1, 8'h03, 1'b0, 1'b1, 0, -1);
    drain();
    cmp("parity_ok_data", 64'(data_b), 64'(40'h0300000000));
    cmp("parity_latency", 64'(last_lat[1]), 64'(110));
    send(1, 8'h03, 1'b1, 1'b1, 0, -1);
    drain();
    cmp("parity_err_count", 64'(n_err[1]), 64'(1));
    cmp("parity_rdy_count", 64'(n_rdy[1]), 64'(1));

    // 2-clock low pulse on idle line: false start
    r0 = n_rdy[0];
    e0 = n_err[0];
    drive(0, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 1'b1);
    repeat (3 * CPS) @(negedge clk);
    cmp("glitch_rdy", 64'(n_rdy[0] - r0), 64'(0));
    cmp("glitch_err", 64'(n_err[0] - e0), 64'(0));

    // 1-clock inverted glitch at the centre of data bit 2
    send(0, 8'h5A, 1'b0, 1'b1, 1, 3);
    drain();
    cmp("glitch_data", 64'(data_a), 64'(40'h5A00000000));

    // timeout drops partial command
    send(0, 8'h80, 1'b0, 1'b1, 0, -1);
    send(0, 8'h11, 1'b0, 1'b1, 0, -1);
    send(0, 8'h05, 1'b0, 1'b1, TOB + 1, -1);
    drain();
    cmp("timeout_data", 64'(data_a), 64'(40'h0500000000));
    cmp("timeout_long", 64'(long_a), 64'(0));

    // gap shorter than the timeout keeps partial command
    send(0, 8'h80, 1'b0, 1'b1, 0, -1);
    send(0, 8'h11, 1'b0, 1'b1, 0, -1);
    send(0, 8'h22, 1'b0, 1'b1, TOB - 2, -1);
    send(0, 8'h33, 1'b0, 1'b1, 0, -1);
    send(0, 8'h44, 1'b0, 1'b1, 0, -1);
    drain();
    cmp("no_timeout_data", 64'(data_a), 64'(40'h8011223344));
    cmp("no_timeout_long", 64'(long_a), 64'(1));

    // reset mid-frame inside a partial long command
    send(0, 8'h80, 1'b0, 1'b1, 0, -1);
    drive(0, 1'b0);
    repeat (25) @(negedge clk);
    run_chk = 1'b0;
    rst_n = 1'b0;
    drive(0, 1'b1);
    model_reset();
    @(negedge clk);
    cmp("midreset_data", 64'(data_a), 64'(0));
    cmp("midreset_rdy", 64'(rdy_a), 64'(0));
    cmp("midreset_long", 64'(long_a), 64'(0));
    cmp("midreset_err", 64'(err_a), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_chk = 1'b1;
    r0 = n_rdy[0];
    e0 = n_err[0];
    repeat (30 * CPS) @(negedge clk);
    cmp("post_reset_rdy", 64'(n_rdy[0] - r0), 64'(0));
    cmp("post_reset_err", 64'(n_err[0] - e0), 64'(0));
    send(0, 8'h06, 1'b0, 1'b1, 0, -1);
    drain();
    cmp("post_reset_data", 64'(data_a), 64'(40'h0600000000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
